// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port 32-bit data memory with a fixed-latency
// request/response handshake, byte/half/word accesses and error detection.
//   clk, rst            : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake (one outstanding request)
//   req_we, req_adr     : store/load select, byte address
//   req_size            : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        : zero-extend (1) or sign-extend (0) loads
//   req_wdata           : right-aligned store data
//   rsp_valid           : one-cycle response strobe, LATENCY cycles after accept
//   rsp_rdata, rsp_err  : extended load data / misaligned-or-illegal flag
module data_mem_ctrl #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        hold_data_q;
  logic               hold_err_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic               rsp_err_q;

  logic [31:0]        mem_q [DEPTH];

  logic               accept_c;
  logic               err_c;
  logic [1:0]         lane_c;
  logic [ADDR_W-1:0]  word_idx_c;
  logic [3:0]         be_c;
  logic [31:0]        wlane_c;
  logic [31:0]        rd_word_c;
  logic [31:0]        rd_shift_c;
  logic [31:0]        load_c;
  logic [31:0]        rsp_data_c;
  logic               unused_adr;

  // Upper address bits are don't-care: the array aliases modulo its depth.
  assign unused_adr = ^req_adr[31:ADDR_W+2];

  assign req_ready  = (state_q != ST_WAIT);
  assign accept_c   = req_valid & req_ready;
  assign lane_c     = req_adr[1:0];
  assign word_idx_c = req_adr[ADDR_W+1:2];
  assign rd_word_c  = mem_q[word_idx_c];
  assign rd_shift_c = rd_word_c >> {lane_c, 3'b000};

  // Size decode: alignment check, byte enables, lane replication, load extension
  always_comb begin
    err_c   = 1'b0;
    be_c    = 4'b0000;
    wlane_c = 32'd0;
    load_c  = 32'd0;
    case (req_size)
      2'b00: begin
        be_c    = 4'b0001 << lane_c;
        wlane_c = {4{req_wdata[7:0]}};
        load_c  = req_unsigned ? {24'd0, rd_shift_c[7:0]}
                               : {{24{rd_shift_c[7]}}, rd_shift_c[7:0]};
      end
      2'b01: begin
        err_c   = lane_c[0];
        be_c    = lane_c[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{req_wdata[15:0]}};
        load_c  = req_unsigned ? {16'd0, rd_shift_c[15:0]}
                               : {{16{rd_shift_c[15]}}, rd_shift_c[15:0]};
      end
      2'b10: begin
        err_c   = (lane_c != 2'b00);
        be_c    = 4'b1111;
        wlane_c = req_wdata;
        load_c  = rd_shift_c;
      end
      default: begin
        err_c = 1'b1;
      end
    endcase
    rsp_data_c = (req_we || err_c) ? 32'd0 : load_c;
  end

  // Storage: no reset; a store commits at its accepting edge so a load
  // accepted on the following edge already sees the new data.
  always_ff @(posedge clk) begin
    if (accept_c && req_we && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem_q[word_idx_c][8*b +: 8] <= wlane_c[8*b +: 8];
      end
    end
  end

  // Handshake FSM with latency counter and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_data_q <= 32'd0;
      hold_err_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (accept_c) begin
            if (LATENCY == 1) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_data_c;
              rsp_err_q   <= err_c;
            end else begin
              state_q     <= ST_WAIT;
              cnt_q       <= CNT_W'(LATENCY - 1);
              hold_data_q <= rsp_data_c;
              hold_err_q  <= err_c;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= ST_RESP;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= hold_data_q;
            rsp_err_q   <= hold_err_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 10, word-address bits (memory depth = 2**ADDR_W 32-bit words).
REQ-002 Parameter: LATENCY, default 2, legal range 1..4, cycles from request acceptance to response.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset.
REQ-005 Port: req_valid  in  1  request present.
REQ-006 Port: req_ready  out  1  block can accept a request this cycle.
REQ-007 Port: req_we  in  1  1 = store, 0 = load.
REQ-008 Port: req_adr  in  32  byte address.
REQ-009 Port: req_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-010 Port: req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 Port: req_wdata  in  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half).
REQ-012 Port: rsp_valid  out  1  one-cycle response strobe.
REQ-013 Port: rsp_rdata  out  32  load result, extended per req_size/req_unsigned; 0 for stores and errors.
REQ-014 Port: rsp_err  out  1  valid with rsp_valid; misaligned access or illegal size.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; one request outstanding at most; no response backpressure.
REQ-016 req_ready = 1 in IDLE and RESP, 0 in WAIT.
REQ-017 Acceptance = req_valid & req_ready at a rising edge; request fields are sampled only at that edge.
REQ-018 On acceptance: LATENCY=1 -> RESP; otherwise -> WAIT with counter loaded to LATENCY-1.
REQ-019 WAIT: counter decrements each cycle; at 1 -> RESP; rsp_valid rises exactly LATENCY cycles after the accepting edge.
REQ-020 RESP: rsp_valid = 1 for exactly one cycle; next state WAIT/RESP on new acceptance (back-to-back), else IDLE.
REQ-021 Word index = req_adr[ADDR_W+1:2]; upper address bits ignored (address wraps modulo depth).
REQ-022 Little-endian byte lanes; req_adr[1:0] selects the lane.
REQ-023 Misaligned = (half with req_adr[0]=1) or (word with req_adr[1:0]!=00); also req_size=11 -> rsp_err=1.
REQ-024 Store commits at the accepting edge, writing only the addressed byte lanes; erroneous stores write nothing.
REQ-025 Load reads array contents at the accepting edge; result held internally until its RESP cycle.
REQ-026 A load accepted in the RESP cycle of a store to the same word returns the newly stored data.
REQ-027 rsp_rdata and rsp_err are 0 whenever rsp_valid = 0.
REQ-028 Memory array is not reset; contents survive rst.

Reset
REQ-029 rst low forces, immediately and without clk: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-030 req_ready = 1 while in reset and in the first cycle after release.
REQ-031 Reset during WAIT or RESP discards the pending response; no rsp_valid is produced for it.

Verification
REQ-032 LATENCY=2: store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-033 Store byte 0x7F @0x11 over 0x00000000, load byte signed @0x11 -> 0x0000007F; store 0x80 @0x12, load signed -> 0xFFFFFF80, unsigned -> 0x00000080.
REQ-034 Load half @0x13 and word @0x22 -> rsp_err 1, rdata 0; preceding word at 0x20 unchanged by a misaligned store.
REQ-035 ADDR_W=10: store word 0x12345678 @0x1000, load @0x0000 -> 0x12345678 (wrap).
REQ-036 Back-to-back: req_valid held high with 3 requests, LATENCY=1 -> accepts on consecutive IDLE/RESP cycles, 3 rsp_valid pulses in order, req_ready never low.
REQ-037 Assert rst low in WAIT of a load -> outputs 0 asynchronously, no rsp_valid after release, earlier stored data still readable.
